stack_controller: RTL and testbench



---
 rtl/stack_controller_pkg.sv | 19 +
 rtl/stack_controller_if.sv | 28 ++
 rtl/stack_controller.sv | 210 +++++++++++++++++++++
 tb/tb_stack_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_controller_pkg.sv
// rtl/stack_controller_pkg.sv - shared op codes and FSM state encodings for the operand stack
package stack_controller_pkg;

  // Request op codes, decoded identically by the CPU control FSM
  typedef enum logic [1:0] {
    STK_OP_DUP  = 2'b00,
    STK_OP_PUSH = 2'b01,
    STK_OP_POP  = 2'b10,
    STK_OP_POP2 = 2'b11
  } stk_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    STK_ST_IDLE   = 2'd0,
    STK_ST_CAP_B  = 2'd1,
    STK_ST_REFILL = 2'd2
  } stk_state_e;

endpackage

// File: rtl/stack_controller_if.sv
// rtl/stack_controller_if.sv - request/response handshake between control FSM and stack
interface stack_controller_if #(
  parameter int DATA_W = 8
);
  import stack_controller_pkg::*;

  logic              req_valid;
  stk_op_e           req_op;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_a;
  logic [DATA_W-1:0] rsp_b;

  // CPU control side
  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_err, rsp_a, rsp_b
  );

  // Stack controller side
  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_err, rsp_a, rsp_b
  );

endinterface

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - operand stack sequencer, TOS register plus external RAM (optional DUP via STACK_DUP_EN)
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  stack_controller_if.slave bus,
  input  logic              err_clr_i,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_ovf_o,
  output logic              err_unf_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   SP_TWO   = (AW+1)'(2);
  localparam logic [AW:0]   CAPACITY = (AW+1)'(DEPTH + 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] ADDR_TWO = AW'(2);

  stk_state_e        state_q, state_d;
  logic [AW:0]       sp_q, sp_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic              tos_valid_q, tos_valid_d;
  logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
  logic [DATA_W-1:0] rsp_b_q, rsp_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;

  logic              ovf_set, unf_set;
  logic              req_ready;
  logic [AW:0]       count;
  logic              full, empty;

  // A valid TOS implies every RAM entry below it is live, so count >= 1 <=> tos_valid
  assign count   = sp_q + (AW+1)'(tos_valid_q);
  assign full    = (count == CAPACITY);
  assign empty   = (count == '0);

  assign count_o   = count;
  assign full_o    = full;
  assign empty_o   = empty;
  assign err_ovf_o = err_ovf_q;
  assign err_unf_o = err_unf_q;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_a     = rsp_a_q;
  assign bus.rsp_b     = rsp_b_q;

  // Next-state, datapath updates and combinational RAM strobes
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    tos_d       = tos_q;
    tos_valid_d = tos_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    req_ready   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;

    case (state_q)
      STK_ST_IDLE: begin
        // Held low while reset is asserted so nothing is accepted during reset
        req_ready = rst_ni;
        if (bus.req_valid && req_ready) begin
          rsp_valid_d = 1'b1;
          case (bus.req_op)
            STK_OP_PUSH: begin
              if (full) begin
                rsp_err_d = 1'b1;
                ovf_set   = 1'b1;
              end else begin
                if (tos_valid_q) begin
                  mem_we_o    = 1'b1;
                  mem_addr_o  = sp_q[AW-1:0];
                  mem_wdata_o = tos_q;
                  sp_d        = sp_q + SP_ONE;
                end
                tos_d       = bus.req_data;
                tos_valid_d = 1'b1;
              end
            end
            STK_OP_POP: begin
              if (!tos_valid_q) begin
                rsp_err_d = 1'b1;
                unf_set   = 1'b1;
              end else begin
                rsp_a_d = tos_q;
                if (sp_q != '0) begin
                  mem_re_o   = 1'b1;
                  mem_addr_o = sp_q[AW-1:0] - ADDR_ONE;
                  state_d    = STK_ST_REFILL;
                end else begin
                  tos_valid_d = 1'b0;
                end
              end
            end
            STK_OP_POP2: begin
              if (count < SP_TWO) begin
                rsp_err_d = 1'b1;
                unf_set   = 1'b1;
              end else begin
                // Response is deferred until the second operand is captured
                rsp_valid_d = 1'b0;
                mem_re_o    = 1'b1;
                mem_addr_o  = sp_q[AW-1:0] - ADDR_ONE;
                state_d     = STK_ST_CAP_B;
              end
            end
            STK_OP_DUP: begin
`ifdef STACK_DUP_EN
              if (!tos_valid_q) begin
                rsp_err_d = 1'b1;
                unf_set   = 1'b1;
              end else if (full) begin
                rsp_err_d = 1'b1;
                ovf_set   = 1'b1;
              end else begin
                mem_we_o    = 1'b1;
                mem_addr_o  = sp_q[AW-1:0];
                mem_wdata_o = tos_q;
                sp_d        = sp_q + SP_ONE;
              end
`else
              rsp_err_d = 1'b1;
`endif
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
      end

      STK_ST_CAP_B: begin
        rsp_a_d     = tos_q;
        rsp_b_d     = mem_rdata_i;
        rsp_valid_d = 1'b1;
        sp_d        = sp_q - SP_ONE;
        if (sp_q >= SP_TWO) begin
          mem_re_o   = 1'b1;
          mem_addr_o = sp_q[AW-1:0] - ADDR_TWO;
          state_d    = STK_ST_REFILL;
        end else begin
          tos_valid_d = 1'b0;
          state_d     = STK_ST_IDLE;
        end
      end

      STK_ST_REFILL: begin
        tos_d   = mem_rdata_i;
        sp_d    = sp_q - SP_ONE;
        state_d = STK_ST_IDLE;
      end

      default: state_d = STK_ST_IDLE;
    endcase

    // A new error in the same cycle as a clear leaves the flag set
    err_ovf_d = ovf_set | (err_ovf_q & ~err_clr_i);
    err_unf_d = unf_set | (err_unf_q & ~err_clr_i);
  end

  // State and datapath registers; reset also abandons any RAM read in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= STK_ST_IDLE;
      sp_q        <= '0;
      tos_q       <= '0;
      tos_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      tos_q       <= tos_d;
      tos_valid_q <= tos_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - scoreboard bench for stack_controller with behavioural RAM
module tb_stack_controller;
  import stack_controller_pkg::*;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW:0]   count;
  logic          full, empty, err_ovf, err_unf;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] ram [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic          err;
    logic          chk_a;
    logic [DW-1:0] a;
    logic          chk_b;
    logic [DW-1:0] b;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  stack_controller_if #(.DATA_W(DW)) bus();

  stack_controller #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .err_clr_i   (err_clr),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .err_ovf_o   (err_ovf),
    .err_unf_o   (err_unf),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_re_o    (mem_re),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_err", bus.rsp_err, e.err);
        if (e.chk_a) chk("rsp_a", bus.rsp_a, e.a);
        if (e.chk_b) chk("rsp_b", bus.rsp_b, e.b);
      end
    end
  end

  task automatic do_req(input stk_op_e op, input logic [DW-1:0] data, input logic err,
                        input logic chk_a, input logic [DW-1:0] a,
                        input logic chk_b, input logic [DW-1:0] b, input int lat);
    exp_t e;
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    e.err = err; e.chk_a = chk_a; e.a = a; e.chk_b = chk_b; e.b = b;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk("rsp_timeout", sb.size(), 0);
    while (!bus.req_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = STK_OP_PUSH;
    bus.req_data  = '0;

    // Reset values
    idle_cycles(3);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_unf", err_unf, 0);
    chk("rst_rsp_a", bus.rsp_a, 0);
    chk("rst_rsp_b", bus.rsp_b, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", bus.req_ready, 1);

    // Three back-to-back pushes
    do_req(STK_OP_PUSH, 8'h11, 0, 0, 0, 0, 0, 1);
    do_req(STK_OP_PUSH, 8'h22, 0, 0, 0, 0, 0, 1);
    do_req(STK_OP_PUSH, 8'h33, 0, 0, 0, 0, 0, 1);
    chk("push3_count", count, 3);
    drain();
    chk("ram0", ram[0], 8'h11);
    chk("ram1", ram[1], 8'h22);

    // POP2 with refill
    do_req(STK_OP_POP2, 8'h00, 0, 1, 8'h33, 1, 8'h22, 2);
    chk("pop2_ready_c1", bus.req_ready, 0);
    idle_cycles(1);
    chk("pop2_ready_c2", bus.req_ready, 0);
    idle_cycles(1);
    chk("pop2_ready_c3", bus.req_ready, 1);
    chk("pop2_count", count, 1);
    do_req(STK_OP_POP, 8'h00, 0, 1, 8'h11, 0, 0, 1);
    chk("pop_empty", empty, 1);
    drain();

    // Underflow and clear priority
    do_req(STK_OP_POP, 8'h00, 1, 0, 0, 0, 0, 1);
    chk("unf_set", err_unf, 1);
    err_clr = 1'b1;
    do_req(STK_OP_POP, 8'h00, 1, 0, 0, 0, 0, 1);
    err_clr = 1'b0;
    chk("unf_set_wins", err_unf, 1);
    err_clr = 1'b1;
    idle_cycles(1);
    err_clr = 1'b0;
    chk("unf_cleared", err_unf, 0);
    do_req(STK_OP_PUSH, 8'h44, 0, 0, 0, 0, 0, 1);
    do_req(STK_OP_POP2, 8'h00, 1, 0, 0, 0, 0, 1);
    chk("pop2_one_unf", err_unf, 1);
    chk("pop2_one_count", count, 1);
    do_req(STK_OP_POP, 8'h00, 0, 1, 8'h44, 0, 0, 1);
    drain();
    err_clr = 1'b1;
    idle_cycles(1);
    err_clr = 1'b0;

    // Fill to capacity, then overflow
    for (int i = 0; i <= DEPTH; i++)
      do_req(STK_OP_PUSH, DW'(8'h80 + i), 0, 0, 0, 0, 0, 1);
    chk("fill_count", count, DEPTH + 1);
    chk("fill_full", full, 1);
    do_req(STK_OP_PUSH, 8'hAA, 1, 0, 0, 0, 0, 1);
    chk("ovf_set", err_ovf, 1);
    chk("ovf_full", full, 1);
    drain();
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
        if (ram[i] !== DW'(8'h80 + i)) bad++;
      chk("ram_after_ovf", bad, 0);
    end
    do_req(STK_OP_POP, 8'h00, 0, 1, 8'h90, 0, 0, 1);
    idle_cycles(1);
    chk("pop_after_full", full, 0);
    chk("pop_after_full_cnt", count, DEPTH);

    // Reset during REFILL
    do_req(STK_OP_POP, 8'h00, 0, 1, 8'h8F, 0, 0, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_mem_re", mem_re, 0);
    chk("midrst_ready", bus.req_ready, 0);
    chk("midrst_ovf", err_ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    do_req(STK_OP_PUSH, 8'h5A, 0, 0, 0, 0, 0, 1);
    do_req(STK_OP_POP, 8'h00, 0, 1, 8'h5A, 0, 0, 1);
    chk("post_rst_pop_count", count, 0);
    drain();

    // Op 00
`ifdef STACK_DUP_EN
    do_req(STK_OP_PUSH, 8'h07, 0, 0, 0, 0, 0, 1);
    do_req(STK_OP_DUP, 8'h00, 0, 0, 0, 0, 0, 1);
    chk("dup_count", count, 2);
    do_req(STK_OP_POP2, 8'h00, 0, 1, 8'h07, 1, 8'h07, 2);
    drain();
    chk("dup_pop2_count", count, 0);
`else
    do_req(STK_OP_DUP, 8'h00, 1, 0, 0, 0, 0, 1);
    chk("op00_ovf", err_ovf, 0);
    chk("op00_unf", err_unf, 0);
    chk("op00_count", count, 0);
    drain();
`endif

    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
